// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I execute-stage definitions: operand width, shift-amount width, ALU opcodes.
package riscv_32i_defs_pkg;
  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_t;
endpackage

// File: rtl/alu_intf.sv
// Bundle of the ALU operand/result signals for hookup of assertion and coverage monitors.
interface alu_intf
  import riscv_32i_defs_pkg::*;
(
  input logic clk,
  input logic rst
);
  alu_op_t         alu_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [XLEN-1:0] result;
  logic            zero;

  modport assertion (input clk, rst, alu_op, in_a, in_b, result, zero);
  modport coverage  (input clk, rst, alu_op, in_a, in_b, result, zero);
endinterface

// File: rtl/alu_shifter.sv
// Log-depth barrel shifter; dir=1 shifts right, arith=1 sign-fills on right shifts.
module alu_shifter
  import riscv_32i_defs_pkg::*;
(
  input  logic [XLEN-1:0]    data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  input  logic               arith,
  output logic [XLEN-1:0]    shifted
);
  logic [SHAMT_W:0][XLEN-1:0] stg;
  logic                       fill;

  assign fill   = arith & data[XLEN-1];
  assign stg[0] = data;

  // stage i moves by 2^i when shamt[i] is set
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int N = 1 << i;
    assign stg[i+1] = !shamt[i] ? stg[i] :
                      dir       ? {{N{fill}}, stg[i][XLEN-1:N]} :
                                  {stg[i][XLEN-1-N:0], {N{1'b0}}};
  end

  assign shifted = stg[SHAMT_W];
endmodule

// File: rtl/rv32i_alu.sv
// RV32I ALU. Combinational by default; define ALU_OUT_REG_EN to register result/zero (1-cycle latency).
module rv32i_alu
  import riscv_32i_defs_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  alu_op_t         alu_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] res_c;
  logic            zero_c;
  logic            sh_right;
  logic            sh_arith;

  assign sh_right = (alu_op == ALU_SRL) || (alu_op == ALU_SRA);
  assign sh_arith = (alu_op == ALU_SRA);

  alu_shifter u_shifter (
    .data    (in_a),
    .shamt   (in_b[SHAMT_W-1:0]),
    .dir     (sh_right),
    .arith   (sh_arith),
    .shifted (shifted)
  );

  always_comb begin
    res_c = '0;
    case (alu_op)
      ALU_AND:  res_c = in_a & in_b;
      ALU_OR:   res_c = in_a | in_b;
      ALU_ADD:  res_c = in_a + in_b;
      ALU_XOR:  res_c = in_a ^ in_b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  res_c = shifted;
      ALU_SUB:  res_c = in_a - in_b;
      ALU_SLT:  res_c = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      ALU_SLTU: res_c = {{(XLEN-1){1'b0}}, in_a < in_b};
      default:  res_c = '0; // unassigned opcodes yield a clean zero
    endcase
  end

  assign zero_c = (res_c == '0);

`ifdef ALU_OUT_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b1;
    end else begin
      result <= res_c;
      zero   <= zero_c;
    end
  end
`else
  // clock and reset only matter for the registered build
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign result         = res_c;
  assign zero           = zero_c;
`endif
endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu; honours ALU_OUT_REG_EN when the same macro is defined for the build.
module tb_rv32i_alu;
  import riscv_32i_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  alu_op_t     alu_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] result;
  logic        zero;

  int n_cmp = 0;
  int n_bad = 0;

  rv32i_alu dut (
    .clk    (clk),
    .rst    (rst),
    .alu_op (alu_op),
    .in_a   (in_a),
    .in_b   (in_b),
    .result (result),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  // Reference model straight from the opcode table
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a << sh;
      4'd5:    return a >> sh;
      4'd6:    return a - b;
      4'd7:    return 32'($signed(a) >>> sh);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Apply operands and wait until the output should reflect them
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op = alu_op_t'(op);
    in_a   = a;
    in_b   = b;
`ifdef ALU_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic test_reset;
    drive(4'd2, 32'd2, 32'd3);
    n_cmp++;
`ifdef ALU_OUT_REG_EN
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_hold: result=%h zero=%b, want 00000000/1", result, zero);
    end
`else
    if (result !== 32'd5 || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ignored: result=%h zero=%b, want 00000005/0", result, zero);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [3:0]  ops [12];
    logic [31:0] as  [12];
    logic [31:0] bs  [12];
    logic [31:0] exp [12];
    ops = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd6, 4'd6, 4'd7, 4'd8, 4'd9, 4'd4, 4'd5};
    as  = '{32'hF0F0_F0F0, 32'h0, 32'h1234_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd0,
            32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    bs  = '{32'hFF00_FF00, 32'h0, 32'h0000_5678, 32'h1, 32'h1, 32'd5, 32'd1,
            32'h0000_0024, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'h0000_003F};
    exp = '{32'hF000_F000, 32'h0, 32'h1234_5678, 32'h0, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF,
            32'hF800_0000, 32'h1, 32'h0, 32'h8000_0000, 32'h0000_0001};
    for (int i = 0; i < 12; i++) begin
      drive(ops[i], as[i], bs[i]);
      n_cmp++;
      if (result !== exp[i] || zero !== (exp[i] == 32'h0)) begin
        n_bad++;
        $display("FAIL directed[%0d]: op=%0d a=%h b=%h result=%h zero=%b, want %h/%b",
                 i, ops[i], as[i], bs[i], result, zero, exp[i], exp[i] == 32'h0);
      end
    end
  endtask

  task automatic test_undefined;
    for (int op = 10; op < 16; op++) begin
      drive(4'(op), $urandom, $urandom);
      n_cmp++;
      if (result !== 32'h0 || zero !== 1'b1) begin
        n_bad++;
        $display("FAIL undefined_op: op=%0d result=%h zero=%b, want 00000000/1", op, result, zero);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0]  op;
    logic [31:0] a, b, exp;
    for (int i = 0; i < 1000; i++) begin
      op = (i < 160) ? 4'(i % 16) : 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 4 == 0) ? a : $urandom;
      exp = ref_alu(op, a, b);
      drive(op, a, b);
      n_cmp++;
      if (result !== exp || zero !== (exp == 32'h0)) begin
        n_bad++;
        $display("FAIL random[%0d]: op=%0d a=%h b=%h result=%h zero=%b, want %h/%b",
                 i, op, a, b, result, zero, exp, exp == 32'h0);
      end
    end
  endtask

  task automatic test_latency;
    logic [31:0] first, second;
    first  = ref_alu(4'd2, 32'd100, 32'd23);
    second = ref_alu(4'd3, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    drive(4'd2, 32'd100, 32'd23);
    alu_op = ALU_XOR;
    in_a   = 32'hA5A5_A5A5;
    in_b   = 32'h0F0F_0F0F;
    #1;
    n_cmp++;
`ifdef ALU_OUT_REG_EN
    if (result !== first) begin
      n_bad++;
      $display("FAIL latency_hold: result=%h, want %h before clock", result, first);
    end
    @(posedge clk);
    #1;
    n_cmp++;
`endif
    if (result !== second || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_update: result=%h zero=%b, want %h/0", result, zero, second);
    end
  endtask

  task automatic test_reset_pulse;
    drive(4'd1, 32'h0000_00FF, 32'h0);
    alu_op = ALU_ADD;
    in_a   = 32'h1111_1111;
    in_b   = 32'h2222_2222;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
`ifdef ALU_OUT_REG_EN
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pulse: result=%h zero=%b, want 00000000/1", result, zero);
    end
`else
    if (result !== 32'h3333_3333 || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pulse: result=%h zero=%b, want 33333333/0", result, zero);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'd6, 32'd9, 32'd4);
    n_cmp++;
    if (result !== 32'd5 || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset: result=%h zero=%b, want 00000005/0", result, zero);
    end
  endtask

  initial begin
    alu_op = ALU_AND;
    in_a   = '0;
    in_b   = '0;
    #3;
    test_reset;
    test_directed;
    test_undefined;
    test_random;
    test_latency;
    test_reset_pulse;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
